sensor_scanner: RTL and testbench
=================================

# sensor_scanner

Acquisition front end of the baggage-drop height path. It polls the four height sensors in turn over a req/ack handshake and captures one 8-bit reading from each. It then publishes all four readings together as a coherent frame, feeding the `sensor1..sensor4` inputs of the height computation. A sensor that fails to answer within a bounded time is reported as 0, which downstream logic already treats as a missing reading.

## Interface

Parameters:
- `TIMEOUT`, 15: maximum cycles `sens_req` stays high for one sensor before that sensor is declared faulty (legal range 1..255).
- `IDLE_GAP`, 4: cycles spent idle between the end of one frame and the start of the next (legal range 0..255).

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: start and continue scanning while high.
- `sens_sel` out 2: index of the sensor being polled (0..3 maps to sensor1..sensor4).
- `sens_req` out 1: request to the selected sensor.
- `sens_ack` in 1: sensor response; qualifies `sens_data`.
- `sens_data` in 8: reading from the selected sensor.
- `sensor1`, `sensor2`, `sensor3`, `sensor4` out 8 each: last published frame.
- `fault` out 4: bit i set means sensor i+1 timed out in the last published frame.
- `frame_valid` out 1: one-cycle pulse marking a newly published frame.

## Operation

- States: IDLE, REQ, GAP, PUBLISH.
  - Internal state: 2-bit sensor index, 8-bit wait counter, 8-bit idle counter.
  - Shadow registers: four 8-bit readings plus 4 fault bits.
- IDLE:
  - `sens_req` is low.
  - The idle counter counts up to `IDLE_GAP`.
  - Once the count is reached and `enable` is high, set index to 0, clear the wait counter, and go to REQ.
  - Coming out of reset, the idle counter is already satisfied, so the first frame starts on the first edge with `enable` high.
- REQ:
  - `sens_req` is high and `sens_sel` equals the index; both stay stable for the whole state.
  - Each edge checks `sens_ack` first, then the timeout, then the count:
    - `sens_ack` high: capture `sens_data` into shadow[index] and clear shadow fault[index].
    - Else, wait counter equal to `TIMEOUT`-1: load 0 into shadow[index] and set shadow fault[index].
    - Else: increment the wait counter.
  - On capture or timeout, go to GAP if index < 3, else to PUBLISH.
- GAP:
  - Exactly one cycle with `sens_req` low.
  - Increment the index, clear the wait counter, return to REQ.
- PUBLISH:
  - On entry, `sensor1..4` and `fault` load from the shadow registers in a single edge.
  - `frame_valid` is high for exactly this one cycle.
  - Clear the idle counter and go to IDLE.
- Published outputs change only on PUBLISH, so a partial frame is never visible.
- `sens_ack` while `sens_req` is low (IDLE, GAP, PUBLISH) is ignored.
- `sens_data` = 0 with `sens_ack` high is a valid reading: stored as 0 with the fault bit clear.
- Ack on the same edge the timeout would fire: the ack wins and the data is captured.
- `enable` falling mid-frame: the current frame completes and publishes, then the block stays in IDLE.
- `enable` rising again: a new frame starts after the gap completes.

## Timing

- Reset values (asynchronous, applied immediately while `rst` is high):
  - State IDLE, index 0, counters 0, shadow registers 0.
  - `sens_req`=0, `sens_sel`=0, `sensor1..4`=0, `fault`=0, `frame_valid`=0.
- Reset mid-frame:
  - `sens_req` drops asynchronously and no publish occurs.
  - Outputs return to 0, not to the previous frame.
- Minimum frame latency, with ack on the first REQ cycle for every sensor:
  - `sens_req` rises after edge E0, where `enable` is sampled in IDLE.
  - `frame_valid` is high in the cycle after edge E8.
- Per sensor:
  - A sensor that acks never sees `sens_req` high for more than `TIMEOUT` cycles.
  - A silent sensor sees `sens_req` high for exactly `TIMEOUT` cycles.
- Frame period with `enable` held high: sum of the REQ cycles + 3 GAP + 1 PUBLISH + `IDLE_GAP` + 1.

## Test plan

- Immediate acks, data 40/42/44/46, `IDLE_GAP`=4:
  - `sensor1..4` = 40/42/44/46, `fault`=0.
  - `frame_valid` one cycle, 8 cycles after `sens_req` first rises.
  - Next `sens_req` 5 cycles after the pulse.
- Sensor 3 silent, `TIMEOUT`=15, others ack on their 3rd REQ cycle with 50:
  - `sens_req` high 15 cycles for sel=2.
  - `sensor3`=0, `fault`=4'b0100, others 50.
- Ack arrives on the exact timeout cycle with data 0x7F: `sensor` = 0x7F, fault bit clear.
- Spurious `sens_ack` pulses during IDLE and GAP: no capture, no index advance, frame contents unchanged.
- `enable` dropped while sel=1:
  - Frame completes and publishes once.
  - No further `sens_req` until `enable` returns.
- `rst` asserted while sel=2 with `sens_req` high:
  - `sens_req` low immediately, all outputs 0, no `frame_valid`.
  - After release, a clean frame starts at sel=0.

Source files
------------

// File: rtl/sensor_scanner_if.sv
// Request/acknowledge link between the scanner and the polled height sensors.
// The master drives the sensor select and request; the slave returns ack and data.
interface sensor_scanner_if;
    logic [1:0] sens_sel;
    logic       sens_req;
    logic       sens_ack;
    logic [7:0] sens_data;

    modport master (output sens_sel, output sens_req, input sens_ack, input sens_data);
    modport slave  (input sens_sel, input sens_req, output sens_ack, output sens_data);
endinterface

// File: rtl/sensor_scanner.sv
// Polls four height sensors in turn, holding readings in shadow registers and
// publishing them as one coherent frame; a silent sensor reads as 0 with its fault bit set.
module sensor_scanner #(
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned IDLE_GAP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    sensor_scanner_if.master bus,
    output logic [7:0]       sensor1,
    output logic [7:0]       sensor2,
    output logic [7:0]       sensor3,
    output logic [7:0]       sensor4,
    output logic [3:0]       fault,
    output logic             frame_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_GAP,
        S_PUBLISH
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_idx;
    logic [7:0] r_wait;
    logic [7:0] r_idle_cnt;
    logic       r_gap_done;
    logic [7:0] r_shadow [4];
    logic [3:0] r_sfault;

    logic w_gap_ok;
    logic w_timeout;
    logic w_last;

    // r_gap_done lets the very first frame after reset start without waiting out the gap
    assign w_gap_ok  = r_gap_done || (r_idle_cnt == 8'(IDLE_GAP));
    assign w_timeout = (r_wait == 8'(TIMEOUT - 1));
    assign w_last    = (r_idx == 2'd3);

    assign bus.sens_req = (r_state == S_REQ);
    assign bus.sens_sel = r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (enable && w_gap_ok) begin
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sens_ack || w_timeout) begin
                    w_next = w_last ? S_PUBLISH : S_GAP;
                end
            end
            S_GAP:     w_next = S_REQ;
            S_PUBLISH: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_wait      <= '0;
            r_idle_cnt  <= '0;
            r_gap_done  <= 1'b1;
            r_sfault    <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
            end
            sensor1     <= '0;
            sensor2     <= '0;
            sensor3     <= '0;
            sensor4     <= '0;
            fault       <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable && w_gap_ok) begin
                        r_idx  <= '0;
                        r_wait <= '0;
                    end else if (r_idle_cnt != 8'(IDLE_GAP)) begin
                        r_idle_cnt <= r_idle_cnt + 8'd1;
                    end
                end
                S_REQ: begin
                    // Ack has priority over the timeout firing on the same edge
                    if (bus.sens_ack) begin
                        r_shadow[r_idx] <= bus.sens_data;
                        r_sfault[r_idx] <= 1'b0;
                    end else if (w_timeout) begin
                        r_shadow[r_idx] <= '0;
                        r_sfault[r_idx] <= 1'b1;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_GAP: begin
                    r_idx  <= r_idx + 2'd1;
                    r_wait <= '0;
                end
                S_PUBLISH: begin
                    sensor1     <= r_shadow[0];
                    sensor2     <= r_shadow[1];
                    sensor3     <= r_shadow[2];
                    sensor4     <= r_shadow[3];
                    fault       <= r_sfault;
                    frame_valid <= 1'b1;
                    r_idle_cnt  <= '0;
                    r_gap_done  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sensor_scanner.sv
// Scoreboard bench for sensor_scanner: a sensor responder answers requests per test
// configuration, and every published frame is checked against queued expectations.
module tb_sensor_scanner;

    typedef struct packed {
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] s4;
        logic [3:0] f;
    } frame_t;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] sensor1, sensor2, sensor3, sensor4;
    logic [3:0] fault;
    logic       frame_valid;

    sensor_scanner_if bus ();

    sensor_scanner #(
        .TIMEOUT  (15),
        .IDLE_GAP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .bus         (bus),
        .sensor1     (sensor1),
        .sensor2     (sensor2),
        .sensor3     (sensor3),
        .sensor4     (sensor4),
        .fault       (fault),
        .frame_valid (frame_valid)
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    frame_t exp_q[$];

    // Responder configuration: ack on the Nth REQ cycle (0 = never answer)
    int         cfg_delay [4];
    logic [7:0] cfg_data  [4];
    logic       cfg_spur;
    int         last_len  [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int         req_cnt;
        logic [1:0] cur_sel;
        req_cnt = 0;
        cur_sel = 2'd0;
        bus.sens_ack  = 1'b0;
        bus.sens_data = 8'h00;
        forever begin
            @(negedge clk);
            if (bus.sens_req) begin
                if (req_cnt == 0) cur_sel = bus.sens_sel;
                req_cnt++;
                bus.sens_ack  = (cfg_delay[cur_sel] != 0) && (req_cnt == cfg_delay[cur_sel]);
                bus.sens_data = bus.sens_ack ? cfg_data[cur_sel] : 8'hA5;
            end else begin
                if (req_cnt != 0) last_len[cur_sel] = req_cnt;
                req_cnt = 0;
                bus.sens_ack  = cfg_spur;
                bus.sens_data = 8'hEE;
            end
        end
    end

    initial begin
        frame_t got;
        frame_t exp;
        forever begin
            @(negedge clk);
            if (!rst && frame_valid) begin
                got = '{s1: sensor1, s2: sensor2, s3: sensor3, s4: sensor4, f: fault};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL frame_unexpected: got %h, required none", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_bad++;
                        $display("FAIL frame_contents: got %h, required %h", got, exp);
                    end
                end
            end
        end
    end

    // kind: 0 req high, 1 frame_valid, 2 req with sel==1, 3 req with sel==2
    task automatic wait_for(input int kind, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            case (kind)
                0: ok = bus.sens_req;
                1: ok = frame_valid;
                2: ok = bus.sens_req && (bus.sens_sel == 2'd1);
                3: ok = bus.sens_req && (bus.sens_sel == 2'd2);
                default: ok = 1'b0;
            endcase
            if (ok) return;
        end
    endtask

    task automatic configure(input int d0, d1, d2, d3, input logic [7:0] v0, v1, v2, v3);
        cfg_delay[0] = d0; cfg_delay[1] = d1; cfg_delay[2] = d2; cfg_delay[3] = d3;
        cfg_data[0]  = v0; cfg_data[1]  = v1; cfg_data[2]  = v2; cfg_data[3]  = v3;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable = 1'b0;
        cfg_spur = 1'b0;
        configure(1, 1, 1, 1, 8'd0, 8'd0, 8'd0, 8'd0);
        #3;
        n_cmp++;
        if ({bus.sens_req, bus.sens_sel, frame_valid, fault} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_ctrl: got req=%b sel=%0d fv=%b fault=%b, required all 0",
                     bus.sens_req, bus.sens_sel, frame_valid, fault);
        end
        n_cmp++;
        if ({sensor1, sensor2, sensor3, sensor4} !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h, required 0", sensor1, sensor2, sensor3, sensor4);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_immediate_ack;
        bit ok;
        int t0, t1, t2;
        configure(1, 1, 1, 1, 8'd40, 8'd42, 8'd44, 8'd46);
        exp_q.push_back('{s1: 8'd40, s2: 8'd42, s3: 8'd44, s4: 8'd46, f: 4'b0000});
        exp_q.push_back('{s1: 8'd40, s2: 8'd42, s3: 8'd44, s4: 8'd46, f: 4'b0000});
        enable = 1'b1;
        wait_for(0, 20, ok);
        t0 = cyc;
        n_cmp++;
        if (!ok || bus.sens_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL first_req: got seen=%b sel=%0d, required seen=1 sel=0", ok, bus.sens_sel);
        end
        wait_for(1, 40, ok);
        t1 = cyc;
        n_cmp++;
        if (!ok || (t1 - t0) != 8) begin
            n_bad++;
            $display("FAIL frame_latency: got seen=%b %0d cycles, required 8", ok, t1 - t0);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL pulse_width: got fv=%b one cycle later, required 0", frame_valid);
        end
        wait_for(0, 20, ok);
        t2 = cyc;
        n_cmp++;
        if (!ok || (t2 - t1) != 5) begin
            n_bad++;
            $display("FAIL frame_period: got seen=%b %0d cycles after pulse, required 5", ok, t2 - t1);
        end
        enable = 1'b0;
        wait_for(1, 40, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL second_frame: got no frame_valid, required one");
        end
    endtask

    task automatic test_timeout;
        bit ok;
        configure(3, 3, 0, 3, 8'd50, 8'd50, 8'd0, 8'd50);
        exp_q.push_back('{s1: 8'd50, s2: 8'd50, s3: 8'd0, s4: 8'd50, f: 4'b0100});
        enable = 1'b1;
        wait_for(0, 40, ok);
        enable = 1'b0;
        wait_for(1, 200, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL timeout_frame: got no frame_valid, required one");
        end
        n_cmp++;
        if (last_len[2] != 15 || last_len[0] != 3) begin
            n_bad++;
            $display("FAIL timeout_len: got sel2=%0d sel0=%0d cycles, required 15 and 3",
                     last_len[2], last_len[0]);
        end
    endtask

    task automatic test_ack_at_timeout;
        bit ok;
        configure(1, 15, 1, 1, 8'd0, 8'h7F, 8'd0, 8'd0);
        exp_q.push_back('{s1: 8'd0, s2: 8'h7F, s3: 8'd0, s4: 8'd0, f: 4'b0000});
        enable = 1'b1;
        wait_for(0, 40, ok);
        enable = 1'b0;
        wait_for(1, 200, ok);
        n_cmp++;
        if (!ok || last_len[1] != 15) begin
            n_bad++;
            $display("FAIL ack_at_timeout: got seen=%b len=%0d, required seen=1 len=15", ok, last_len[1]);
        end
    endtask

    task automatic test_spurious_ack;
        bit ok;
        configure(2, 2, 2, 2, 8'd1, 8'd2, 8'd3, 8'd4);
        exp_q.push_back('{s1: 8'd1, s2: 8'd2, s3: 8'd3, s4: 8'd4, f: 4'b0000});
        cfg_spur = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b1;
        wait_for(0, 40, ok);
        enable = 1'b0;
        wait_for(1, 200, ok);
        cfg_spur = 1'b0;
        n_cmp++;
        if (!ok || last_len[0] != 2 || last_len[1] != 2 || last_len[2] != 2 || last_len[3] != 2) begin
            n_bad++;
            $display("FAIL spurious_ack: got seen=%b lens=%0d/%0d/%0d/%0d, required 2/2/2/2",
                     ok, last_len[0], last_len[1], last_len[2], last_len[3]);
        end
    endtask

    task automatic test_enable_drop;
        bit ok;
        int highs;
        configure(1, 1, 1, 1, 8'd9, 8'd8, 8'd7, 8'd6);
        exp_q.push_back('{s1: 8'd9, s2: 8'd8, s3: 8'd7, s4: 8'd6, f: 4'b0000});
        enable = 1'b1;
        wait_for(2, 60, ok);
        enable = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL enable_drop_sel1: got no request on sel 1, required one");
        end
        wait_for(1, 60, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL enable_drop_frame: got no frame_valid, required one");
        end
        highs = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.sens_req) highs++;
        end
        n_cmp++;
        if (highs != 0) begin
            n_bad++;
            $display("FAIL enable_drop_idle: got %0d request cycles, required 0", highs);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        configure(2, 2, 2, 2, 8'h11, 8'h22, 8'h33, 8'h44);
        enable = 1'b1;
        wait_for(3, 60, ok);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (!ok || bus.sens_req !== 1'b0 || bus.sens_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_async_req: got seen=%b req=%b sel=%0d, required seen=1 req=0 sel=0",
                     ok, bus.sens_req, bus.sens_sel);
        end
        n_cmp++;
        if ({sensor1, sensor2, sensor3, sensor4, fault, frame_valid} !== 37'h0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %h %h %h %h fault=%b fv=%b, required 0",
                     sensor1, sensor2, sensor3, sensor4, fault, frame_valid);
        end
        repeat (2) @(negedge clk);
        exp_q.push_back('{s1: 8'h11, s2: 8'h22, s3: 8'h33, s4: 8'h44, f: 4'b0000});
        rst = 1'b0;
        wait_for(0, 10, ok);
        n_cmp++;
        if (!ok || bus.sens_sel !== 2'd0) begin
            n_bad++;
            $display("FAIL restart_sel: got seen=%b sel=%0d, required seen=1 sel=0", ok, bus.sens_sel);
        end
        enable = 1'b0;
        wait_for(1, 60, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL restart_frame: got no frame_valid, required one");
        end
    endtask

    initial begin
        test_reset();
        test_immediate_ack();
        test_timeout();
        test_ack_at_timeout();
        test_spurious_ack();
        test_enable_drop();
        test_reset_mid_frame();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL frames_outstanding: got %0d unpublished, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
